fx_convert_arbiter: RTL and testbench

FX_CONVERT_ARBITER -- requirements
Module: fx_convert_arbiter

---
 rtl/fx_convert_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fx_convert_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_convert_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : fx_convert_arbiter                                                |
// | Purpose  : round-robin arbiter feeding a two-stage fixed-point converter     |
// |            with saturation flagging and response/saturation statistics.      |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module fx_convert_arbiter #(
    parameter int FX_M_IN  = 4,
    parameter int FX_B_IN  = 15,
    parameter int FX_M_OUT = 2,
    parameter int FX_B_OUT = 7,
    parameter int N_REQ    = 2,
    parameter int CNT_W    = 16,
    localparam int c_ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ*(1+FX_B_IN)-1:0] req_data_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [FX_B_OUT:0]            resp_data_o,
    output logic [c_ID_W-1:0]            resp_id_o,
    output logic                         resp_sat_o,
    output logic [CNT_W-1:0]             conv_cnt_o,
    output logic [CNT_W-1:0]             sat_cnt_o
);

    localparam int c_W_IN  = FX_B_IN + 1;
    localparam int c_W_OUT = FX_B_OUT + 1;
    localparam int c_F_IN  = FX_B_IN - FX_M_IN;
    localparam int c_F_OUT = FX_B_OUT - FX_M_OUT;
    localparam int c_SHL   = (c_F_OUT >= c_F_IN) ? (c_F_OUT - c_F_IN) : 0;
    localparam int c_SHR   = (c_F_OUT <  c_F_IN) ? (c_F_IN - c_F_OUT) : 0;
    localparam int c_WIDE  = c_W_IN + c_SHL + c_W_OUT;

    generate
        if (FX_B_IN < FX_M_IN) begin : g_bad_in_fmt
            $error("fx_convert_arbiter: FX_B_IN must be >= FX_M_IN");
        end
        if (FX_B_OUT < FX_M_OUT) begin : g_bad_out_fmt
            $error("fx_convert_arbiter: FX_B_OUT must be >= FX_M_OUT");
        end
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
            $error("fx_convert_arbiter: N_REQ must be in 2..8");
        end
    endgenerate

    logic                      r_s1_valid;
    logic [c_W_IN-1:0]         r_s1_data;
    logic [c_ID_W-1:0]         r_s1_id;
    logic [c_ID_W-1:0]         r_rr_ptr;
    logic                      r_resp_valid;
    logic [c_W_OUT-1:0]        r_resp_data;
    logic [c_ID_W-1:0]         r_resp_id;
    logic                      r_resp_sat;
    logic [CNT_W-1:0]          r_conv_cnt;
    logic [CNT_W-1:0]          r_sat_cnt;

    logic                      w_stall;
    logic                      w_s1_accept;
    logic                      w_gnt_any;
    logic [c_ID_W-1:0]         w_gnt_idx;
    logic [c_W_IN-1:0]         w_gnt_data;
    logic                      w_take;
    logic [N_REQ-1:0]          w_ready;
    logic signed [c_WIDE-1:0]  w_ext;
    logic signed [c_WIDE-1:0]  w_aligned;
    logic [c_WIDE-c_W_OUT:0]   w_hi;
    logic                      w_fits;
    logic [c_W_OUT-1:0]        w_conv;

    assign w_stall     = r_resp_valid & ~resp_ready_i;
    assign w_s1_accept = ~r_s1_valid | ~w_stall;

    // Outer loop runs farthest-first so the nearest valid requester after rr_ptr wins.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (((int'(r_rr_ptr) + k) % N_REQ) == i && req_valid_i[i]) begin
                    w_gnt_any  = 1'b1;
                    w_gnt_idx  = c_ID_W'(i);
                    w_gnt_data = req_data_i[i*c_W_IN +: c_W_IN];
                end
            end
        end
    end

    assign w_take = w_gnt_any & w_s1_accept & ~rst_i;

    always_comb begin
        w_ready = '0;
        if (w_take) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Sign-extend into a wide word so the alignment shift never overflows, then
    // the value fits iff every bit from the output sign upward agrees.
    assign w_ext     = signed'({{(c_WIDE-c_W_IN){r_s1_data[c_W_IN-1]}}, r_s1_data});
    assign w_aligned = (w_ext <<< c_SHL) >>> c_SHR;
    assign w_hi      = w_aligned[c_WIDE-1:c_W_OUT-1];
    assign w_fits    = (&w_hi) | ~(|w_hi);

    always_comb begin
        if (w_fits) begin
            w_conv = w_aligned[c_W_OUT-1:0];
        end else if (r_s1_data[c_W_IN-1]) begin
            w_conv = {1'b1, {FX_B_OUT{1'b0}}};
        end else begin
            w_conv = {1'b0, {FX_B_OUT{1'b1}}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_id      <= '0;
            r_rr_ptr     <= c_ID_W'(N_REQ - 1);
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_resp_sat   <= 1'b0;
            r_conv_cnt   <= '0;
            r_sat_cnt    <= '0;
        end else begin
            if (r_resp_valid && resp_ready_i) begin
                r_conv_cnt <= r_conv_cnt + CNT_W'(1);
                if (r_resp_sat) begin
                    r_sat_cnt <= r_sat_cnt + CNT_W'(1);
                end
            end
            if (!w_stall) begin
                r_resp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_resp_data <= w_conv;
                    r_resp_id   <= r_s1_id;
                    r_resp_sat  <= ~w_fits;
                end
            end
            if (w_s1_accept) begin
                r_s1_valid <= w_take;
                if (w_take) begin
                    r_s1_data <= w_gnt_data;
                    r_s1_id   <= w_gnt_idx;
                    r_rr_ptr  <= w_gnt_idx;
                end
            end
        end
    end

    assign req_ready_o  = w_ready;
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;
    assign resp_id_o    = r_resp_id;
    assign resp_sat_o   = r_resp_sat;
    assign conv_cnt_o   = r_conv_cnt;
    assign sat_cnt_o    = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fx_convert_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_fx_convert_arbiter                                             |
// | Purpose  : directed bench with a cycle-level reference model for the DUT.    |
// | Revision : 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_fx_convert_arbiter;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [31:0] req_data_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [7:0]  resp_data_o;
    logic [0:0]  resp_id_o;
    logic        resp_sat_o;
    logic [15:0] conv_cnt_o;
    logic [15:0] sat_cnt_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fx_convert_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_data_i   (req_data_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_id_o    (resp_id_o),
        .resp_sat_o   (resp_sat_o),
        .conv_cnt_o   (conv_cnt_o),
        .sat_cnt_o    (sat_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Q4.11 -> Q2.5: divide by 64 rounding toward minus infinity, then clamp.
    function automatic void conv_model(input logic [15:0] x, output logic [7:0] y, output bit sat);
        int v;
        int q;
        v = int'($signed(x));
        if (v >= 0) q = v / 64;
        else        q = -((-v + 63) / 64);
        sat = 1'b0;
        if (q > 127) begin
            q = 127;
            sat = 1'b1;
        end else if (q < -128) begin
            q = -128;
            sat = 1'b1;
        end
        y = 8'(q);
    endfunction

    function automatic void grant_model(input logic [1:0] v, input int ptr, output bit found, output int g);
        found = 1'b0;
        g = 0;
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) begin
                found = 1'b1;
                g = (ptr + k) % N;
                break;
            end
        end
    endfunction

    // Reference model: two occupancy slots plus statistics.
    bit          m_s1_v, m_s2_v, m_s2_sat;
    logic [15:0] m_s1_x;
    int          m_s1_id, m_s2_id, m_ptr;
    logic [7:0]  m_s2_y;
    logic [15:0] m_conv, m_sat;

    initial begin
        m_s1_v = 0; m_s2_v = 0; m_s2_sat = 0; m_s1_x = 0; m_s1_id = 0;
        m_s2_id = 0; m_ptr = N - 1; m_s2_y = 0; m_conv = 0; m_sat = 0;
    end

    always @(posedge clk) begin
        bit   stall, accept, found, s;
        int   g;
        logic [7:0] y;
        if (rst_i) begin
            m_s1_v = 0; m_s2_v = 0; m_s2_sat = 0; m_s2_y = 0; m_s2_id = 0;
            m_ptr = N - 1; m_conv = 0; m_sat = 0;
        end else begin
            stall  = m_s2_v && !resp_ready_i;
            accept = !m_s1_v || !stall;
            grant_model(req_valid_i, m_ptr, found, g);
            if (m_s2_v && resp_ready_i) begin
                m_conv = m_conv + 16'd1;
                if (m_s2_sat) m_sat = m_sat + 16'd1;
            end
            if (!stall) begin
                m_s2_v = m_s1_v;
                if (m_s1_v) begin
                    conv_model(m_s1_x, y, s);
                    m_s2_y = y; m_s2_sat = s; m_s2_id = m_s1_id;
                end
            end
            if (accept) begin
                m_s1_v = found;
                if (found) begin
                    m_s1_x = req_data_i[g*16 +: 16];
                    m_s1_id = g;
                    m_ptr = g;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit   e_found;
        int   e_g;
        logic [1:0] e_ready;
        if (chk_en) begin
            grant_model(req_valid_i, m_ptr, e_found, e_g);
            e_ready = 2'b00;
            if (!rst_i && e_found && (!m_s1_v || !(m_s2_v && !resp_ready_i)))
                e_ready[e_g] = 1'b1;
            check("model req_ready", req_ready_o, e_ready);
            check("model resp_valid", resp_valid_o, m_s2_v);
            if (m_s2_v) begin
                check("model resp_data", resp_data_o, m_s2_y);
                check("model resp_id", resp_id_o, m_s2_id);
                check("model resp_sat", resp_sat_o, m_s2_sat);
            end
            check("model conv_cnt", conv_cnt_o, m_conv);
            check("model sat_cnt", sat_cnt_o, m_sat);
        end
    end

    task automatic send_one(input int i, input logic [15:0] d);
        int n;
        req_data_i[i*16 +: 16] = d;
        req_valid_i[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready_o[i] && n < 20);
        if (!req_ready_o[i]) check("send timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid_i[i] = 1'b0;
    endtask

    task automatic wait_resp(input string name, input logic [7:0] d, input int id, input bit sat, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid_o && lat < 20);
        if (!resp_valid_o) begin
            check({name, " timeout"}, 0, 1);
        end else begin
            check({name, " data"}, resp_data_o, d);
            check({name, " id"}, resp_id_o, id);
            check({name, " sat"}, resp_sat_o, sat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic [7:0] expd [3];
        rst_i = 1'b1; req_valid_i = 2'b00; req_data_i = '0; resp_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset resp_valid", resp_valid_o, 0);
        check("reset req_ready", req_ready_o, 0);
        check("reset conv_cnt", conv_cnt_o, 0);
        check("reset resp_data", resp_data_o, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_en = 1'b1;

        // single conversion and its latency
        send_one(0, 16'h0800);
        wait_resp("one", 8'h20, 0, 1'b0, lat);
        check("one latency", lat, 2);
        check("one conv_cnt", conv_cnt_o, 1);

        // saturation both directions
        send_one(0, 16'h7800);
        wait_resp("pos sat", 8'h7F, 0, 1'b1, lat);
        send_one(0, 16'h8000);
        wait_resp("neg sat", 8'h80, 0, 1'b1, lat);
        check("sat_cnt", sat_cnt_o, 2);
        check("conv_cnt 3", conv_cnt_o, 3);

        // floor truncation
        send_one(0, 16'h0801);
        wait_resp("trunc pos", 8'h20, 0, 1'b0, lat);
        send_one(0, 16'hFFFF);
        wait_resp("trunc m1", 8'hFF, 0, 1'b0, lat);
        send_one(0, 16'hF800);
        wait_resp("trunc neg", 8'hE0, 0, 1'b0, lat);

        // alternating grants, full throughput; last grant was req0 so req1 leads
        req_data_i = {16'h1000, 16'h0800};
        req_valid_i = 2'b11;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) check("rr first ready", req_ready_o, 2'b10);
            if (j >= 2) begin
                check("rr resp_valid", resp_valid_o, 1);
                check("rr id", resp_id_o, ((j - 2) % 2 == 0) ? 1 : 0);
                check("rr data", resp_data_o, ((j - 2) % 2 == 0) ? 8'h40 : 8'h20);
            end
        end
        @(posedge clk);
        #1;
        req_valid_i = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // back-pressure: fill both stages, hold, release
        resp_ready_i = 1'b0;
        req_data_i[31:16] = 16'h1000;
        req_valid_i = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("stall ready", req_ready_o, 2'b00);
            check("stall valid", resp_valid_o, 1);
            check("stall data", resp_data_o, 8'h40);
            check("stall id", resp_id_o, 1);
        end
        @(posedge clk);
        #1;
        resp_ready_i = 1'b1;
        req_data_i[31:16] = 16'h1800;
        expd[0] = 8'h40; expd[1] = 8'h40; expd[2] = 8'h60;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("drain valid", resp_valid_o, 1);
            check("drain data", resp_data_o, expd[j]);
            @(posedge clk);
            #1;
            if (j == 0) req_valid_i = 2'b00;
        end
        @(negedge clk);
        check("drain empty", resp_valid_o, 0);

        // reset with both stages full
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        req_data_i = {16'h1000, 16'h0800};
        req_valid_i = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        check("rst ready", req_ready_o, 2'b00);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        resp_ready_i = 1'b1;
        @(negedge clk);
        check("post rst valid", resp_valid_o, 0);
        check("post rst conv", conv_cnt_o, 0);
        check("post rst sat", sat_cnt_o, 0);
        check("post rst grant", req_ready_o, 2'b01);
        @(posedge clk);
        #1;
        req_valid_i = 2'b00;
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
